regfile_write_arbiter: RTL and testbench

Shares the register file's single write port among `NUM_REQ` writeback sources, such as ALU writeback, load return and a multi-cycle mul/div unit. Each source gets a valid/ready handshake and a one-entry holding buffer. The block arbitrates one write per cycle, blocks write-after-write reordering to the same register, and exports a pending-write bitmap for hazard/stall logic. It sits between the writeback sources and the register file's `reg_write`/`write_reg`/`write_data` inputs.

---
 rtl/regfile_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port among NUM_REQ sources; RF_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
// Latency: accept->buffer 1 cycle, buffer->rf_* 1 cycle; backpressure via req_ready (full buffer or same-register WAW hazard).
module regfile_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic                        rf_reg_write,
  output logic [ADDR_W-1:0]           rf_write_reg,
  output logic [DATA_W-1:0]           rf_write_data,
  output logic [(1<<ADDR_W)-1:0]      pending
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]  buf_addr_q [NUM_REQ];
  logic [ADDR_W-1:0]  buf_addr_d [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_q [NUM_REQ];
  logic [DATA_W-1:0]  buf_data_d [NUM_REQ];

  logic               rf_reg_write_q, rf_reg_write_d;
  logic [ADDR_W-1:0]  rf_write_reg_q, rf_write_reg_d;
  logic [DATA_W-1:0]  rf_write_data_q, rf_write_data_d;

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] waw_block;
  logic [NUM_REQ-1:0] rdy;
  logic [NUM_REQ-1:0] accept;

`ifndef RF_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_q, last_d;
`endif

  // Grant looks only at buffered state, so it never depends on req_valid.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
`ifdef RF_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (buf_valid_q[k]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
`else
    // Walk backwards so the smallest offset from last+1 is the final winner.
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (buf_valid_q[(int'(last_q) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      end
    end
`endif
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    waw_block = '0;
    rdy       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_addr[i*ADDR_W +: ADDR_W] != '0) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (j != i && buf_valid_q[j] && !grant[j] &&
              buf_addr_q[j] == req_addr[i*ADDR_W +: ADDR_W])
            waw_block[i] = 1'b1;
        end
        // Same-cycle collision: a lower index that will be accepted wins.
        for (int j = 0; j < i; j++) begin
          if (req_valid[j] && rdy[j] &&
              req_addr[j*ADDR_W +: ADDR_W] == req_addr[i*ADDR_W +: ADDR_W])
            waw_block[i] = 1'b1;
        end
      end
      rdy[i] = (!buf_valid_q[i] || grant[i]) && !waw_block[i];
    end
  end

  assign req_ready = rdy;
  assign accept    = req_valid & rdy;

  always_comb begin
    buf_valid_d     = buf_valid_q & ~grant;
    buf_addr_d      = buf_addr_q;
    buf_data_d      = buf_data_q;
    rf_reg_write_d  = grant_any;
    rf_write_reg_d  = rf_write_reg_q;
    rf_write_data_d = rf_write_data_q;
    if (grant_any) begin
      rf_write_reg_d  = buf_addr_q[grant_idx];
      rf_write_data_d = buf_data_q[grant_idx];
    end
    // Writes to register 0 complete the handshake but are dropped here.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (accept[i] && req_addr[i*ADDR_W +: ADDR_W] != '0) begin
        buf_valid_d[i] = 1'b1;
        buf_addr_d[i]  = req_addr[i*ADDR_W +: ADDR_W];
        buf_data_d[i]  = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifndef RF_ARB_FIXED_PRIO_EN
  always_comb begin
    last_d = last_q;
    if (grant_any) last_d = grant_idx;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q     <= '0;
      rf_reg_write_q  <= 1'b0;
      rf_write_reg_q  <= '0;
      rf_write_data_q <= '0;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_q          <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      buf_valid_q     <= buf_valid_d;
      rf_reg_write_q  <= rf_reg_write_d;
      rf_write_reg_q  <= rf_write_reg_d;
      rf_write_data_q <= rf_write_data_d;
`ifndef RF_ARB_FIXED_PRIO_EN
      last_q          <= last_d;
`endif
    end
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (buf_valid_q[i]) pending[buf_addr_q[i]] = 1'b1;
    end
    if (rf_reg_write_q) pending[rf_write_reg_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign rf_reg_write  = rf_reg_write_q;
  assign rf_write_reg  = rf_write_reg_q;
  assign rf_write_data = rf_write_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table plus hand-written contention and mid-operation reset sequences.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [31:0] pending;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rf_reg_write (rf_reg_write),
    .rf_write_reg (rf_write_reg),
    .rf_write_data(rf_write_data),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  vld;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic        chk;
    logic [2:0]  rdy;
    logic        we;
    logic [4:0]  rg;
    logic [31:0] dat;
    logic [31:0] pend;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [2:0] v,
                              input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1,
                              input logic [4:0] a2, input logic [31:0] d2,
                              input logic c, input logic [2:0] rdy, input logic we,
                              input logic [4:0] rg, input logic [31:0] dat,
                              input logic [31:0] pend);
    vec_t t;
    t.rst = r; t.vld = v;
    t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
    t.chk = c; t.rdy = rdy; t.we = we; t.rg = rg; t.dat = dat; t.pend = pend;
    return t;
  endfunction

  task automatic check(input string nm, input int step, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] v,
                       input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2);
    rst       = r;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  vec_t vt[26];
  logic [4:0]  exp_reg;

  initial begin
    drive(1'b1, 3'b000, 0, 0, 0, 0, 0, 0);

    // reset with requests valid
    vt[0]  = mk(1, 3'b111, 1, 0, 2, 0, 3, 0,                 0, 3'b000, 0, 0, 0, 0);
    vt[1]  = mk(1, 3'b111, 1, 0, 2, 0, 3, 0,                 1, 3'b111, 0, 0, 0, 0);
    vt[2]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 0, 0, 0);
    // single write: req1 -> r5
    vt[3]  = mk(0, 3'b010, 0, 0, 5, 32'hDEADBEEF, 0, 0,      1, 3'b111, 0, 0, 0, 0);
    vt[4]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 0, 0, 32'h20);
    vt[5]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 5, 32'hDEADBEEF, 32'h20);
    vt[6]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 5, 32'hDEADBEEF, 0);
    // zero register
    vt[7]  = mk(0, 3'b001, 0, 32'h99, 0, 0, 0, 0,            1, 3'b111, 0, 5, 32'hDEADBEEF, 0);
    vt[8]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 5, 32'hDEADBEEF, 0);
    vt[9]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 5, 32'hDEADBEEF, 0);
    // WAW: buf1 holds r7 while buf0 wins; req2 to r7 must wait
    vt[10] = mk(0, 3'b011, 9, 32'h33, 7, 32'h11, 0, 0,       1, 3'b111, 0, 5, 32'hDEADBEEF, 0);
    vt[11] = mk(0, 3'b100, 0, 0, 0, 0, 7, 32'h22,            1, 3'b001, 0, 5, 32'hDEADBEEF, 32'h280);
    vt[12] = mk(0, 3'b100, 0, 0, 0, 0, 7, 32'h22,            1, 3'b111, 1, 9, 32'h33, 32'h280);
    vt[13] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 7, 32'h11, 32'h80);
    vt[14] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 7, 32'h22, 32'h80);
    vt[15] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 7, 32'h22, 0);
    // simultaneous same-address: lower index accepted first
    vt[16] = mk(0, 3'b011, 12, 32'hA0, 12, 32'hA1, 0, 0,     1, 3'b101, 0, 7, 32'h22, 0);
    vt[17] = mk(0, 3'b010, 0, 0, 12, 32'hA1, 0, 0,           1, 3'b111, 0, 7, 32'h22, 32'h1000);
    vt[18] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 12, 32'hA0, 32'h1000);
    vt[19] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 12, 32'hA1, 32'h1000);
    vt[20] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 12, 32'hA1, 0);
    // sole requester back-to-back
    vt[21] = mk(0, 3'b001, 3, 32'h300, 0, 0, 0, 0,           1, 3'b111, 0, 12, 32'hA1, 0);
    vt[22] = mk(0, 3'b001, 4, 32'h400, 0, 0, 0, 0,           1, 3'b111, 0, 12, 32'hA1, 32'h8);
    vt[23] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 3, 32'h300, 32'h18);
    vt[24] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 1, 4, 32'h400, 32'h10);
    vt[25] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,                 1, 3'b111, 0, 4, 32'h400, 0);

    for (int s = 0; s < 26; s++) begin
      @(negedge clk);
      drive(vt[s].rst, vt[s].vld, vt[s].a0, vt[s].d0, vt[s].a1, vt[s].d1,
            vt[s].a2, vt[s].d2);
      #1;
      if (vt[s].chk) begin
        check("req_ready", s, 64'(req_ready), 64'(vt[s].rdy));
        check("rf_reg_write", s, 64'(rf_reg_write), 64'(vt[s].we));
        check("rf_write_reg", s, 64'(rf_write_reg), 64'(vt[s].rg));
        check("rf_write_data", s, 64'(rf_write_data), 64'(vt[s].dat));
        check("pending", s, 64'(pending), 64'(vt[s].pend));
      end
    end

    // contention: all three continuously valid after a fresh reset
    @(negedge clk);
    drive(1'b1, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1'b0, 3'b111, 1, 32'hC0, 2, 32'hC1, 3, 32'hC2);
    #1;
    check("cont_ready", 100, 64'(req_ready), 64'(3'b111));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("cont_pending", 101, 64'(pending), 64'(32'hE));
    for (int k = 0; k < 6; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_reg = 5'd1;
`else
      exp_reg = 5'(k % 3 + 1);
`endif
      check("cont_we", 110 + k, 64'(rf_reg_write), 64'(1));
      check("cont_reg", 110 + k, 64'(rf_write_reg), 64'(exp_reg));
      check("cont_data", 110 + k, 64'(rf_write_data), 64'(32'hBF + 32'(exp_reg)));
      @(negedge clk);
      #1;
    end

    // reset mid-operation with all three buffers full
    @(negedge clk);
    drive(1'b1, 3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1'b0, 3'b000, 0, 0, 0, 0, 0, 0);
    #1;
    check("mrst_reg", 200, 64'(rf_write_reg), 64'(0));
    check("mrst_data", 200, 64'(rf_write_data), 64'(0));
    for (int k = 0; k < 4; k++) begin
      check("mrst_we", 201 + k, 64'(rf_reg_write), 64'(0));
      check("mrst_pending", 201 + k, 64'(pending), 64'(0));
      check("mrst_ready", 201 + k, 64'(req_ready), 64'(3'b111));
      @(negedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
